// File: rtl/rv_muldiv.sv
// rv_muldiv: RV32M multiply/divide unit with valid/ready handshakes on both sides.
// Define RV_MULDIV_FASTMUL_EN to replace the iterative multiplier with a single-cycle one.
module rv_muldiv #(
    parameter int unsigned Width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [Width-1:0] in_a,
    input  logic [Width-1:0] in_b,
    input  logic [4:0]       in_rd,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [Width-1:0] out_res,
    output logic [4:0]       out_rd
);
    localparam int unsigned CntW = $clog2(Width);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    state_e           state_q;
    op_e              op_q;
    logic [Width-1:0] hi_q, lo_q, m_q, res_q;
    logic [CntW-1:0]  cnt_q;
    logic             neg_q, rneg_q;
    logic [4:0]       rd_q;

    logic             a_sgn, b_sgn, a_neg, b_neg, is_div, div_zero, div_ovf;
    logic [Width-1:0] mag_a, mag_b, special_res;
    logic [Width:0]   sum_d, shifted_d, diff_d;
    logic [Width-1:0] step_hi_d, step_lo_d, quo_d, rem_d, final_res_d;
    logic [2*Width-1:0] prod_d;
`ifdef RV_MULDIV_FASTMUL_EN
    logic [2*Width-1:0] fa, fb, fprod;
    logic [Width-1:0]   fast_res;
`endif

    // Request decode: operands are reduced to magnitudes so one unsigned datapath serves all ops.
    always_comb begin
        a_sgn    = (in_op == OP_MULH) || (in_op == OP_MULHSU) || (in_op == OP_DIV) || (in_op == OP_REM);
        b_sgn    = (in_op == OP_MULH) || (in_op == OP_DIV) || (in_op == OP_REM);
        a_neg    = a_sgn && in_a[Width-1];
        b_neg    = b_sgn && in_b[Width-1];
        mag_a    = a_neg ? -in_a : in_a;
        mag_b    = b_neg ? -in_b : in_b;
        is_div   = in_op[2];
        div_zero = is_div && (in_b == '0);
        div_ovf  = is_div && !in_op[0] && (in_a == {1'b1, {(Width-1){1'b0}}}) && (in_b == '1);
        special_res = '0;
        if (div_zero) begin
            special_res = in_op[1] ? in_a : '1;
        end else if (div_ovf) begin
            special_res = in_op[1] ? '0 : in_a;
        end
`ifdef RV_MULDIV_FASTMUL_EN
        fa       = {{Width{a_neg}}, in_a};
        fb       = {{Width{b_neg}}, in_b};
        fprod    = fa * fb;
        fast_res = (in_op[1:0] == 2'b00) ? fprod[Width-1:0] : fprod[2*Width-1:Width];
`endif
    end

    // One iteration: shift-add multiply in {hi,lo}, or restoring divide with remainder in hi.
    always_comb begin
        sum_d     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
        shifted_d = {hi_q, lo_q[Width-1]};
        diff_d    = shifted_d - {1'b0, m_q};
        if (op_q[2]) begin
            if (!diff_d[Width]) begin
                step_hi_d = diff_d[Width-1:0];
                step_lo_d = {lo_q[Width-2:0], 1'b1};
            end else begin
                step_hi_d = shifted_d[Width-1:0];
                step_lo_d = {lo_q[Width-2:0], 1'b0};
            end
        end else begin
            step_hi_d = sum_d[Width:1];
            step_lo_d = {sum_d[0], lo_q[Width-1:1]};
        end
        prod_d = neg_q ? -{step_hi_d, step_lo_d} : {step_hi_d, step_lo_d};
        quo_d  = neg_q ? -step_lo_d : step_lo_d;
        rem_d  = rneg_q ? -step_hi_d : step_hi_d;
        case (op_q)
            OP_MUL:                       final_res_d = prod_d[Width-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: final_res_d = prod_d[2*Width-1:Width];
            OP_DIV, OP_DIVU:              final_res_d = quo_d;
            default:                      final_res_d = rem_d;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= OP_MUL;
            hi_q    <= '0;
            lo_q    <= '0;
            m_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            rd_q    <= '0;
        end else if (flush) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    op_q <= op_e'(in_op);
                    rd_q <= in_rd;
                    if (div_zero || div_ovf) begin
                        res_q   <= special_res;
                        state_q <= DONE;
                    end
`ifdef RV_MULDIV_FASTMUL_EN
                    else if (!is_div) begin
                        res_q   <= fast_res;
                        state_q <= DONE;
                    end
`endif
                    else begin
                        hi_q    <= '0;
                        lo_q    <= is_div ? mag_a : mag_b;
                        m_q     <= is_div ? mag_b : mag_a;
                        neg_q   <= a_neg ^ b_neg;
                        rneg_q  <= a_neg;
                        cnt_q   <= CntW'(Width - 1);
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    hi_q <= step_hi_d;
                    lo_q <= step_lo_d;
                    if (cnt_q == '0) begin
                        res_q   <= final_res_d;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                DONE: if (out_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign out_res   = res_q;
    assign out_rd    = rd_q;
endmodule

// File: tb/tb_rv_muldiv.sv
// Scoreboard bench for rv_muldiv: directed vectors, expected results queued at issue, checked by a monitor.
module tb_rv_muldiv;
    localparam int W = 32;
`ifdef RV_MULDIV_FASTMUL_EN
    localparam int MulLat = 1;
`else
    localparam int MulLat = 33;
`endif
    localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
    localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

    logic         clk, rst, in_valid, in_ready, flush, out_valid, out_ready;
    logic [2:0]   in_op;
    logic [W-1:0] in_a, in_b, out_res;
    logic [4:0]   in_rd, out_rd;

    rv_muldiv #(.Width(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_rd(in_rd), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_res(out_res), .out_rd(out_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] res;
        logic [4:0]   rd;
        int           cyc;
        string        name;
    } exp_t;

    exp_t       sbq[$];
    exp_t       cur;
    int         checks = 0;
    int         fails = 0;
    bit         pend = 0;
    bit         hs_prev = 0;
    logic [4:0] next_rd = 5'd1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Monitor: outputs sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (hs_prev) begin
            chk("post_hs_out_valid", 64'(out_valid), 64'd0);
            chk("post_hs_in_ready", 64'(in_ready), 64'd1);
        end
        hs_prev = 0;
        if (out_valid) begin
            if (!pend) begin
                if (sbq.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_result: got out_valid=1 res=%0h rd=%0d required no result", out_res, out_rd);
                end else begin
                    cur  = sbq.pop_front();
                    pend = 1;
                    chk({cur.name, "_latency"}, 64'(cyc), 64'(cur.cyc));
                end
            end
            if (pend) begin
                chk({cur.name, "_res"}, 64'(out_res), 64'(cur.res));
                chk({cur.name, "_rd"}, 64'(out_rd), 64'(cur.rd));
                chk({cur.name, "_in_ready_done"}, 64'(in_ready), 64'd0);
            end
            if (out_ready && !flush && !rst) begin
                pend    = 0;
                hs_prev = 1;
            end
        end
        if (flush || rst) pend = 0;
    end

    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [4:0] rd, output int acc, output bit ok);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_rd    = rd;
        ok       = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready && !flush) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        acc      = cyc;
        if (!ok) begin
            checks++;
            fails++;
            $display("FAIL issue_timeout: got in_ready=0 for 200 cycles required 1");
        end
    endtask

    task automatic run(input string name, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] exp, input int lat);
        int   acc;
        bit   ok;
        exp_t e;
        issue(op, a, b, next_rd, acc, ok);
        if (ok) begin
            e.res  = exp;
            e.rd   = next_rd;
            e.cyc  = acc + lat - 1;
            e.name = name;
            sbq.push_back(e);
        end
        next_rd = next_rd + 5'd1;
    endtask

    task automatic drain();
        int n = 0;
        while ((sbq.size() != 0 || pend) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0 || pend) begin
            checks++;
            fails++;
            $display("FAIL drain_timeout: got %0d results outstanding required 0", sbq.size());
            sbq.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc;
        bit ok;
        rst = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_rd = '0;
        flush = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_res", 64'(out_res), 64'd0);
        chk("rst_out_rd", 64'(out_rd), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_release_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        run("mul_7_m3",    MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, MulLat);
        run("mul_shift",   MUL,    32'h12345678, 32'h10,       32'h23456780, MulLat);
        run("mulhu_ff",    MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MulLat);
        run("mulh_ff",     MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, MulLat);
        run("mulhsu_m1_2", MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, MulLat);
        run("mulhu_pow",   MULHU,  32'h80000000, 32'd4,        32'h00000002, MulLat);
        run("mulh_min2",   MULH,   32'h80000000, 32'h80000000, 32'h40000000, MulLat);
        run("div_m7_2",    DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
        run("rem_m7_2",    REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
        run("div_7_m2",    DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33);
        run("rem_7_m2",    REM,    32'd7,        32'hFFFFFFFE, 32'd1,        33);
        run("remu_100_7",  REMU,   32'd100,      32'd7,        32'd2,        33);
        run("divu_big",    DIVU,   32'hFFFFFFFF, 32'h10,       32'h0FFFFFFF, 33);
        run("divu_zero",   DIVU,   32'd100,      32'd0,        32'hFFFFFFFF, 1);
        run("remu_zero",   REMU,   32'd100,      32'd0,        32'd100,      1);
        run("div_zero",    DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1);
        run("rem_m5_zero", REM,    32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1);
        run("div_ovf",     DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        run("rem_ovf",     REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1);
        run("div_min_1",   DIV,    32'h80000000, 32'd1,        32'h80000000, 33);
        drain();

        // Backpressure: result held for several cycles before release.
        out_ready = 1'b0;
        run("bp_divu_zero", DIVU, 32'd100, 32'd0, 32'hFFFFFFFF, 1);
        for (int i = 0; i < 50 && !out_valid; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain();

        // Flush in IDLE must beat acceptance of a one-cycle request.
        flush = 1'b1; in_valid = 1'b1; in_op = DIVU; in_a = 32'd100; in_b = 32'd0; in_rd = 5'd30;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_idle_out_valid", 64'(out_valid), 64'd0);
        chk("flush_idle_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // Flush in BUSY cycle 10 with a competing request.
        issue(DIV, 32'hFFFFFFF9, 32'd2, 5'd29, acc, ok);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1; in_valid = 1'b1; in_op = MUL; in_a = 32'd7; in_b = 32'd3; in_rd = 5'd28;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_busy_in_ready", 64'(in_ready), 64'd1);
        chk("flush_busy_out_valid", 64'(out_valid), 64'd0);
        repeat (40) @(negedge clk);
        @(posedge clk); #1;

        // Reset mid-BUSY with a competing request.
        issue(DIVU, 32'd9, 32'd3, 5'd27, acc, ok);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1; in_valid = 1'b1; in_op = DIVU; in_a = 32'd100; in_b = 32'd0; in_rd = 5'd26;
        @(negedge clk);
        chk("rst_busy_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("rst_busy_release_in_ready", 64'(in_ready), 64'd1);
        chk("rst_busy_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy_out_res", 64'(out_res), 64'd0);
        chk("rst_busy_out_rd", 64'(out_rd), 64'd0);
        repeat (40) @(negedge clk);
        @(posedge clk); #1;

        run("divu_9_3", DIVU, 32'd9, 32'd3, 32'd3, 33);
        drain();
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
